// File: rtl/instr_encoder.sv
// instr_encoder: re-encodes control bundles into 9-bit instructions, buffers them in a FIFO
// and writes them sequentially into instruction memory.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic [1:0]        WriteSrc,
  input  logic [1:0]        ALUOp,
  input  logic              MemWrite,
  input  logic              BranchEn,
  input  logic              Alt,
  input  logic [5:0]        Operand,
  input  logic              Last,
  input  logic              ImemStall,
  output logic              ImemWe,
  output logic [ADDR_W-1:0] ImemAddr,
  output logic [8:0]        ImemData,
  output logic [ADDR_W:0]   Count,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE, ERR} state_t;
  state_t            state_q, state_d;
  logic [9:0]        mem_q [DEPTH];
  logic [PW:0]       wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [2:0]        op;
  logic              legal, empty, full, active, accept, push, last_addr, ovf;
  logic [9:0]        head;
  always_comb begin
    legal = 1'b1;
    op = 3'd0;
    case ({WriteSrc, ALUOp, MemWrite, BranchEn})
      6'b000000: op = 3'd0;
      6'b000100: op = 3'd1;
      6'b011000: op = 3'd2;
      6'b111010: op = 3'd3;
      6'b101000: op = 3'd4;
      6'b110101: op = 3'd5;
      6'b111000: op = {2'b11, Alt};
      default:   legal = 1'b0;
    endcase
  end
  assign empty     = wp_q == rp_q;
  assign full      = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign head      = mem_q[rp_q[PW-1:0]];
  assign active    = state_q == LOAD || state_q == DRAIN;
  assign InReady   = Reset && !Start && state_q == LOAD && !full;
  assign accept    = InValid && InReady;
  assign push      = accept && legal;
  assign ImemWe    = Reset && !Start && active && !empty && !ImemStall;
  assign ImemData  = empty ? 9'd0 : head[9:1];
  assign ImemAddr  = addr_q;
  assign Count     = count_q;
  assign last_addr = addr_q == {ADDR_W{1'b1}};
  // a non-Last word landing in the final slot means the program cannot fit
  assign ovf       = ImemWe && last_addr && !head[0];
  assign Busy      = active;
  assign Done      = state_q == DONE;
  assign Error     = state_q == ERR;
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q + (PW+1)'(push);
    rp_d    = rp_q + (PW+1)'(ImemWe);
    addr_d  = (ImemWe && !last_addr) ? addr_q + ADDR_W'(1) : addr_q;
    count_d = count_q + (ADDR_W+1)'(ImemWe);
    if ((accept && !legal) || ovf) begin
      state_d = ERR;
      wp_d    = '0;
      rp_d    = '0;
    end else if (accept && Last) begin
      state_d = DRAIN;
    end else if (state_q == DRAIN && empty) begin
      state_d = DONE;
    end
    if (Start) begin
      state_d = LOAD;
      wp_d    = '0;
      rp_d    = '0;
      addr_d  = '0;
      count_d = '0;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (push) mem_q[wp_q[PW-1:0]] <= {op, Operand, Last};
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: drives an ADDR_W=8 and an ADDR_W=2 encoder in parallel, checking both
// every cycle against a queue-based model plus hand-computed expectations.
module tb_instr_encoder;
  logic       Clk, Reset, Start, InValid, Alt, Last, ImemStall;
  logic [5:0] bun, Operand;
  logic       rdy0, we0, busy0, done0, err0, rdy1, we1, busy1, done1, err1;
  logic [7:0] addr0;
  logic [1:0] addr1;
  logic [8:0] data0, data1, cnt0;
  logic [2:0] cnt1;
  int checks = 0, passes = 0, cyc = 0;
  bit armed = 0;
  int ph [2], n [2], ad [2], ct [2];
  int cap [2] = '{256, 4};
  logic [9:0] q [2][8];
  int lg_n [2];
  int lg_a [2][16], lg_d [2][16], lg_t [2][16];
  localparam logic [5:0] BUN [8] = '{6'b000000, 6'b000100, 6'b011000, 6'b111010,
                                     6'b101000, 6'b110101, 6'b111000, 6'b111000};
  instr_encoder #(.ADDR_W(8), .DEPTH(4)) u_big (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(rdy0),
    .WriteSrc(bun[5:4]), .ALUOp(bun[3:2]), .MemWrite(bun[1]), .BranchEn(bun[0]), .Alt(Alt),
    .Operand(Operand), .Last(Last), .ImemStall(ImemStall), .ImemWe(we0), .ImemAddr(addr0),
    .ImemData(data0), .Count(cnt0), .Busy(busy0), .Done(done0), .Error(err0));
  instr_encoder #(.ADDR_W(2), .DEPTH(4)) u_small (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(rdy1),
    .WriteSrc(bun[5:4]), .ALUOp(bun[3:2]), .MemWrite(bun[1]), .BranchEn(bun[0]), .Alt(Alt),
    .Operand(Operand), .Last(Last), .ImemStall(ImemStall), .ImemWe(we1), .ImemAddr(addr1),
    .ImemData(data1), .Count(cnt1), .Busy(busy1), .Done(done1), .Error(err1));
  always #5 Clk = ~Clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask
  function automatic logic [3:0] enc(input logic [5:0] b, input logic alt);
    for (int k = 0; k < 8; k++)
      if (BUN[k] == b && (k < 6 || alt == k[0])) return {1'b1, 3'(k)};
    return 4'b0;
  endfunction
  // model: compare this cycle's outputs, record DUT writes, then advance on this cycle's inputs
  always @(negedge Clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      logic erdy, ewe, bad, was_empty, awe;
      logic [9:0] w;
      logic [3:0] e;
      int p0;
      erdy = Reset && !Start && ph[i] == 1 && n[i] < 4;
      ewe  = Reset && !Start && (ph[i] == 1 || ph[i] == 2) && n[i] > 0 && !ImemStall;
      awe  = i ? we1 : we0;
      if (armed) begin
        chk($sformatf("InReady%0d", i), i ? rdy1 : rdy0, erdy);
        chk($sformatf("ImemWe%0d", i), awe, ewe);
        chk($sformatf("ImemAddr%0d", i), i ? 32'(addr1) : 32'(addr0), ad[i]);
        chk($sformatf("Count%0d", i), i ? 32'(cnt1) : 32'(cnt0), ct[i]);
        chk($sformatf("Busy%0d", i), i ? busy1 : busy0, ph[i] == 1 || ph[i] == 2);
        chk($sformatf("Done%0d", i), i ? done1 : done0, ph[i] == 3);
        chk($sformatf("Error%0d", i), i ? err1 : err0, ph[i] == 4);
        if (ewe) chk($sformatf("ImemData%0d", i), i ? data1 : data0, q[i][0][9:1]);
      end
      if (!Reset || Start) lg_n[i] = 0;
      else if (awe && lg_n[i] < 16) begin
        lg_a[i][lg_n[i]] = i ? 32'(addr1) : 32'(addr0);
        lg_d[i][lg_n[i]] = i ? 32'(data1) : 32'(data0);
        lg_t[i][lg_n[i]] = cyc;
        lg_n[i]++;
      end
      if (!Reset) begin
        ph[i] = 0; n[i] = 0; ad[i] = 0; ct[i] = 0;
      end else if (Start) begin
        ph[i] = 1; n[i] = 0; ad[i] = 0; ct[i] = 0;
      end else begin
        p0 = ph[i];
        was_empty = n[i] == 0;
        bad = 0;
        if (ewe) begin
          w = q[i][0];
          for (int k = 0; k < 7; k++) q[i][k] = q[i][k+1];
          n[i]--;
          ct[i]++;
          if (ad[i] == cap[i] - 1) bad = !w[0];
          else ad[i]++;
        end
        if (erdy && InValid) begin
          e = enc(bun, Alt);
          if (!e[3]) bad = 1;
          else if (!bad) begin
            q[i][n[i]] = {e[2:0], Operand, Last};
            n[i]++;
            if (Last) ph[i] = 2;
          end
        end
        if (bad) begin
          ph[i] = 4; n[i] = 0;
        end else if (p0 == 2 && was_empty) ph[i] = 3;
      end
    end
    if (!Reset) armed = 1;
  end
  task automatic start();
    Start = 1;
    @(posedge Clk); #1;
    Start = 0;
  endtask
  task automatic send(input logic [5:0] b, input logic alt, input logic [5:0] opnd, input logic last);
    bit ok = 0;
    bun = b; Alt = alt; Operand = opnd; Last = last; InValid = 1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge Clk);
      ok = rdy0;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge Clk); #1;
    InValid = 0;
  endtask
  task automatic push(input int op, input logic [5:0] opnd, input logic last);
    send(BUN[op], op == 7, opnd, last);
  endtask
  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge Clk);
      ok = done0;
    end
    chk("done_wait", ok, 1);
    @(posedge Clk); #1;
  endtask
  initial begin
    Clk = 0; Reset = 0; Start = 0; InValid = 0; bun = 0; Alt = 0; Operand = 0; Last = 0; ImemStall = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ready", rdy0, 0);
    chk("rst_we", we0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_data", data0, 0);
    chk("rst_flags", {busy0, done0, err0}, 0);
    Reset = 1;
    start();
    push(0, 6'h05, 0); push(1, 6'h3F, 0); push(5, 6'h01, 1);
    wait_done();
    chk("t1_nwrites", lg_n[0], 3);
    chk("t1_d0", lg_d[0][0], 9'h005); chk("t1_a0", lg_a[0][0], 0);
    chk("t1_d1", lg_d[0][1], 9'h07F); chk("t1_a1", lg_a[0][1], 1);
    chk("t1_d2", lg_d[0][2], 9'h141); chk("t1_a2", lg_a[0][2], 2);
    chk("t1_count", cnt0, 3);
    start();
    push(6, 6'h12, 0); push(7, 6'h12, 1);
    wait_done();
    chk("t2_swp", lg_d[0][0], 9'h192);
    chk("t2_lim", lg_d[0][1], 9'h1D2);
    start();
    push(2, 6'h01, 0); push(4, 6'h02, 0); send(6'b010000, 0, 6'h03, 0);
    repeat (4) @(posedge Clk);
    #1;
    chk("t3_error", err0, 1);
    chk("t3_ready", rdy0, 0);
    chk("t3_count", cnt0, 2);
    chk("t3_nwrites", lg_n[0], 2);
    start();
    ImemStall = 1;
    fork
      begin
        repeat (10) @(posedge Clk);
        #1 ImemStall = 0;
      end
      begin
        for (int k = 1; k <= 4; k++) push(1, 6'(k), 0);
        @(negedge Clk);
        chk("t4_full_ready", rdy0, 0);
        @(posedge Clk); #1;
        push(1, 6'd5, 0); push(1, 6'd6, 1);
      end
    join
    wait_done();
    chk("t4_nwrites", lg_n[0], 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t4_d%0d", k), lg_d[0][k], 9'h040 + k + 1);
      chk($sformatf("t4_a%0d", k), lg_a[0][k], k);
    end
    chk("t4_nogap", lg_t[0][5] - lg_t[0][0], 5);
    start();
    for (int k = 1; k <= 5; k++) push(0, 6'(k), 0);
    repeat (3) @(posedge Clk);
    #1;
    chk("t5_nwrites", lg_n[1], 4);
    chk("t5_a3", lg_a[1][3], 3);
    chk("t5_d3", lg_d[1][3], 9'h004);
    chk("t5_error", err1, 1);
    chk("t5_count", cnt1, 4);
    start();
    ImemStall = 1;
    push(0, 6'h01, 0); push(0, 6'h02, 0); push(0, 6'h03, 1);
    Reset = 0; ImemStall = 0;
    @(negedge Clk);
    chk("t6_we_in_reset", we0, 0);
    @(posedge Clk); #1;
    chk("t6_idle", {busy0, done0, err0}, 0);
    chk("t6_count", cnt0, 0);
    chk("t6_we", we0, 0);
    Reset = 1;
    start();
    push(0, 6'h07, 1);
    wait_done();
    chk("t6_nwrites", lg_n[0], 1);
    chk("t6_a0", lg_a[0][0], 0);
    chk("t6_d0", lg_d[0][0], 9'h007);
    chk("t6_count2", cnt0, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
